// File: rtl/seq_divider_radix2.sv
// Sequential radix-2 restoring divider: one quotient bit per cycle, start/busy/valid handshake
// and STAGE output register stages. Define SEQ_DIVIDER_DBZ_FLAG_EN to add the div_by_zero port.
module seq_divider_radix2 #(
   parameter int WIDTH_N = 32,
   parameter int WIDTH_D = 16,
   parameter int SIGNED  = 0,
   parameter int STAGE   = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH_N-1:0] dividend,
   input  logic [WIDTH_D-1:0] divisor,
   output logic               busy,
   output logic               valid,
   output logic [WIDTH_N-1:0] quotient,
   output logic [WIDTH_D-1:0] remainder
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
   ,
   output logic               div_by_zero
`endif
);

   localparam int CW = $clog2(WIDTH_N + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH_D-1:0] prem_q, prem_d;
   logic [WIDTH_N-1:0] quo_q, quo_d;
   logic [WIDTH_D-1:0] dvs_q, dvs_d;
   logic [WIDTH_D-1:0] dvd_lo_q, dvd_lo_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dbz_q, dbz_d;
   logic               busy_q, busy_d;
   logic               res_vld_q, res_vld_d;
   logic [WIDTH_N-1:0] res_quo_q, res_quo_d;
   logic [WIDTH_D-1:0] res_rem_q, res_rem_d;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
   logic               res_dbz_q, res_dbz_d;
`endif

   logic               dvd_neg_s, dvs_neg_s;
   logic [WIDTH_N-1:0] dvd_abs_s;
   logic [WIDTH_D-1:0] dvs_abs_s;
   logic [WIDTH_D:0]   shift_s, trial_s;

   // Operand magnitudes and the trial subtraction of the current step
   always_comb begin
      dvd_neg_s = (SIGNED != 0) && dividend[WIDTH_N-1];
      dvs_neg_s = (SIGNED != 0) && divisor[WIDTH_D-1];
      dvd_abs_s = dvd_neg_s ? -dividend : dividend;
      dvs_abs_s = dvs_neg_s ? -divisor : divisor;
      shift_s   = {prem_q, quo_q[WIDTH_N-1]};
      trial_s   = shift_s - {1'b0, dvs_q};
   end

   // Next-state and datapath updates
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prem_d    = prem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      dvd_lo_d  = dvd_lo_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      busy_d    = busy_q;
      res_vld_d = 1'b0;
      res_quo_d = res_quo_q;
      res_rem_d = res_rem_q;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
      res_dbz_d = res_dbz_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               quo_d     = dvd_abs_s;
               dvs_d     = dvs_abs_s;
               dvd_lo_d  = dividend[WIDTH_D-1:0];
               neg_quo_d = dvd_neg_s ^ dvs_neg_s;
               neg_rem_d = dvd_neg_s;
               dbz_d     = (divisor == '0);
               cnt_d     = CW'(WIDTH_N);
               prem_d    = '0;
               busy_d    = 1'b1;
               state_d   = CALC;
            end else begin
               state_d   = IDLE;
            end
         end
         CALC: begin
            // A zero divisor still walks the counter so latency matches; FIX overrides the result
            prem_d = trial_s[WIDTH_D] ? shift_s[WIDTH_D-1:0] : trial_s[WIDTH_D-1:0];
            quo_d  = {quo_q[WIDTH_N-2:0], ~trial_s[WIDTH_D]};
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = FIX;
            end else begin
               state_d = CALC;
            end
         end
         FIX: begin
            if (dbz_q) begin
               res_quo_d = '1;
               res_rem_d = dvd_lo_q;
            end else begin
               res_quo_d = neg_quo_q ? -quo_q : quo_q;
               res_rem_d = neg_rem_q ? -prem_q : prem_q;
            end
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
            res_dbz_d = dbz_q;
`endif
            res_vld_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Core state and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         prem_q    <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         dvd_lo_q  <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         res_vld_q <= 1'b0;
         res_quo_q <= '0;
         res_rem_q <= '0;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
         res_dbz_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prem_q    <= prem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         dvd_lo_q  <= dvd_lo_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         busy_q    <= busy_d;
         res_vld_q <= res_vld_d;
         res_quo_q <= res_quo_d;
         res_rem_q <= res_rem_d;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
         res_dbz_q <= res_dbz_d;
`endif
      end
   end

   assign busy = busy_q;

   generate
      if (STAGE == 0) begin : g_nopipe
         assign valid     = res_vld_q;
         assign quotient  = res_quo_q;
         assign remainder = res_rem_q;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
         assign div_by_zero = res_dbz_q;
`endif
      end else begin : g_pipe
         // Stages shift every cycle; the held result register keeps the output stable between pulses
         logic               pv_q [STAGE], pv_d [STAGE];
         logic [WIDTH_N-1:0] pq_q [STAGE], pq_d [STAGE];
         logic [WIDTH_D-1:0] pr_q [STAGE], pr_d [STAGE];
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
         logic               pz_q [STAGE], pz_d [STAGE];
`endif

         // Shift network feeding the output stages
         always_comb begin
            pv_d[0] = res_vld_q;
            pq_d[0] = res_quo_q;
            pr_d[0] = res_rem_q;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
            pz_d[0] = res_dbz_q;
`endif
            for (int i = 1; i < STAGE; i++) begin
               pv_d[i] = pv_q[i-1];
               pq_d[i] = pq_q[i-1];
               pr_d[i] = pr_q[i-1];
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
               pz_d[i] = pz_q[i-1];
`endif
            end
         end

         // Output stage registers
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < STAGE; i++) begin
                  pv_q[i] <= 1'b0;
                  pq_q[i] <= '0;
                  pr_q[i] <= '0;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
                  pz_q[i] <= 1'b0;
`endif
               end
            end else begin
               for (int i = 0; i < STAGE; i++) begin
                  pv_q[i] <= pv_d[i];
                  pq_q[i] <= pq_d[i];
                  pr_q[i] <= pr_d[i];
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
                  pz_q[i] <= pz_d[i];
`endif
               end
            end
         end

         assign valid     = pv_q[STAGE-1];
         assign quotient  = pq_q[STAGE-1];
         assign remainder = pr_q[STAGE-1];
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
         assign div_by_zero = pz_q[STAGE-1];
`endif
      end
   endgenerate

endmodule

// File: tb/tb_seq_divider_radix2.sv
// Scoreboard bench for seq_divider_radix2: unsigned/STAGE=0, signed/STAGE=0 and unsigned/STAGE=3
// instances, checked against an integer-arithmetic reference model.
module tb_seq_divider_radix2;

   localparam int WN = 32;
   localparam int WD = 16;

   typedef struct {
      logic [WN-1:0] q;
      logic [WD-1:0] r;
      logic          z;
      int            at_edge;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_s [3];
   logic [WN-1:0] dvd_s   [3];
   logic [WD-1:0] dvs_s   [3];
   logic          busy_s  [3];
   logic          vld_s   [3];
   logic [WN-1:0] quo_s   [3];
   logic [WD-1:0] rem_s   [3];
   logic          dbz_s   [3];

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb0[$];
   exp_t sb1[$];
   exp_t sb2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_divider_radix2 #(.WIDTH_N(WN), .WIDTH_D(WD), .SIGNED(0), .STAGE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .dividend(dvd_s[0]), .divisor(dvs_s[0]),
      .busy(busy_s[0]), .valid(vld_s[0]), .quotient(quo_s[0]), .remainder(rem_s[0])
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
      , .div_by_zero(dbz_s[0])
`endif
   );
   seq_divider_radix2 #(.WIDTH_N(WN), .WIDTH_D(WD), .SIGNED(1), .STAGE(0)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .dividend(dvd_s[1]), .divisor(dvs_s[1]),
      .busy(busy_s[1]), .valid(vld_s[1]), .quotient(quo_s[1]), .remainder(rem_s[1])
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
      , .div_by_zero(dbz_s[1])
`endif
   );
   seq_divider_radix2 #(.WIDTH_N(WN), .WIDTH_D(WD), .SIGNED(0), .STAGE(3)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start_s[2]), .dividend(dvd_s[2]), .divisor(dvs_s[2]),
      .busy(busy_s[2]), .valid(vld_s[2]), .quotient(quo_s[2]), .remainder(rem_s[2])
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
      , .div_by_zero(dbz_s[2])
`endif
   );

   // Reference: truncating division, remainder follows the dividend's sign
   function automatic exp_t model(input bit sgn, input logic [WN-1:0] n, input logic [WD-1:0] d);
      exp_t   e;
      longint sn, sd, t;
      e.z = 1'b0;
      e.at_edge = 0;
      if (d == 16'h0) begin
         e.q = '1;
         e.r = n[WD-1:0];
         e.z = 1'b1;
      end else if (sgn) begin
         sn = $signed(n);
         sd = $signed(d);
         if (sn == -64'sd2147483648 && sd == -64'sd1) begin
            e.q = 32'h8000_0000;
            e.r = 16'h0;
         end else begin
            t = sn / sd;
            e.q = t[WN-1:0];
            t = sn % sd;
            e.r = t[WD-1:0];
         end
      end else begin
         e.q = n / {16'h0, d};
         t = longint'(n % {16'h0, d});
         e.r = t[WD-1:0];
      end
      return e;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [WN-1:0] act, input logic [WN-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, idx, act, req, cyc);
      end
   endtask

   task automatic push(input int idx, input exp_t e);
      case (idx)
         0:       sb0.push_back(e);
         1:       sb1.push_back(e);
         default: sb2.push_back(e);
      endcase
   endtask

   // Called at a negedge; start is sampled at the next edge (T0). Returns at the negedge after T0.
   task automatic issue(input int idx, input logic [WN-1:0] n, input logic [WD-1:0] d);
      exp_t e;
      e = model(idx == 1, n, d);
      e.at_edge = cyc + 1 + WN + 2 + ((idx == 2) ? 3 : 0);
      push(idx, e);
      dvd_s[idx]   = n;
      dvs_s[idx]   = d;
      start_s[idx] = 1'b1;
      @(negedge clk);
      start_s[idx] = 1'b0;
      dvd_s[idx]   = $urandom();
      dvs_s[idx]   = 16'($urandom());
   endtask

   task automatic mon(input int idx);
      exp_t e;
      bit   have;
      have = 1'b0;
      if (vld_s[idx] === 1'b1) begin
         case (idx)
            0:       if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
            1:       if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
            default: if (sb2.size() > 0) begin e = sb2.pop_front(); have = 1'b1; end
         endcase
         if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid dut%0d at edge %0d", idx, cyc + 1);
         end else begin
            chk("quotient", idx, quo_s[idx], e.q);
            chk("remainder", idx, {16'h0, rem_s[idx]}, {16'h0, e.r});
            chk("latency_edge", idx, cyc + 1, e.at_edge);
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
            chk("div_by_zero", idx, {31'h0, dbz_s[idx]}, {31'h0, e.z});
`endif
         end
      end
   endtask

   // Monitor: outputs are sampled on the falling edge, i.e. the value the next rising edge sees
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) mon(i);
   end

   task automatic drain();
      int k;
      k = 0;
      while ((sb0.size() + sb1.size() + sb2.size()) > 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if ((sb0.size() + sb1.size() + sb2.size()) > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results still expected, required 0", sb0.size() + sb1.size() + sb2.size());
      end
   endtask

   task automatic random_run(input int idx, input int cnt);
      logic [WN-1:0] n;
      logic [WD-1:0] d;
      int            sel;
      for (int k = 0; k < cnt; k++) begin
         sel = $urandom_range(0, 9);
         n = $urandom();
         case (sel)
            0:       d = 16'h0;
            1:       d = 16'h1;
            2:       d = 16'hFFFF;
            3:       begin n = 32'h8000_0000; d = 16'hFFFF; end
            4:       d = 16'($urandom_range(2, 15));
            5:       begin n = $urandom_range(0, 1000); d = 16'($urandom()); end
            default: d = 16'($urandom());
         endcase
         issue(idx, n, d);
         repeat (WN + 1) @(negedge clk);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         start_s[i] = 1'b0;
         dvd_s[i]   = '0;
         dvs_s[i]   = '0;
      end
      #12;
      for (int i = 0; i < 3; i++) begin
         chk("reset_busy", i, {31'h0, busy_s[i]}, 32'h0);
         chk("reset_valid", i, {31'h0, vld_s[i]}, 32'h0);
         chk("reset_quotient", i, quo_s[i], 32'h0);
         chk("reset_remainder", i, {16'h0, rem_s[i]}, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Unsigned 100/7 with busy profile, then back-to-back divide by zero
      issue(0, 32'd100, 16'd7);
      chk("busy_first", 0, {31'h0, busy_s[0]}, 32'h1);
      for (int j = 0; j < WN; j++) begin
         @(negedge clk);
         chk("busy_calc", 0, {31'h0, busy_s[0]}, 32'h1);
      end
      @(negedge clk);
      chk("busy_done", 0, {31'h0, busy_s[0]}, 32'h0);
      issue(0, 32'h1234_5678, 16'h0);
      repeat (WN + 1) @(negedge clk);

      // start during CALC is ignored
      issue(0, 32'd100, 16'd7);
      repeat (4) @(negedge clk);
      dvd_s[0] = 32'd555;
      dvs_s[0] = 16'd3;
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (WN + 1 - 5) @(negedge clk);
      random_run(0, 20);

      // Signed cases, overflow twice back-to-back
      issue(1, 32'hFFFF_FF9C, 16'd7);
      repeat (WN + 1) @(negedge clk);
      issue(1, 32'd100, 16'hFFF9);
      repeat (WN + 1) @(negedge clk);
      issue(1, 32'h8000_0000, 16'hFFFF);
      repeat (WN + 1) @(negedge clk);
      issue(1, 32'h8000_0000, 16'hFFFF);
      repeat (WN + 1) @(negedge clk);
      issue(1, 32'h1234_5678, 16'h0);
      repeat (WN + 1) @(negedge clk);
      random_run(1, 25);

      // Pipelined instance
      issue(2, 32'd100, 16'd7);
      repeat (WN + 1) @(negedge clk);
      random_run(2, 15);
      drain();

      // Reset mid-operation: outputs clear at once, aborted result never appears
      issue(0, 32'd100, 16'd7);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      sb0.delete();
      #1;
      chk("abort_busy", 0, {31'h0, busy_s[0]}, 32'h0);
      chk("abort_valid", 0, {31'h0, vld_s[0]}, 32'h0);
      chk("abort_quotient", 0, quo_s[0], 32'h0);
      chk("abort_remainder", 0, {16'h0, rem_s[0]}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (WN + 10) @(negedge clk);
      issue(0, 32'd1000, 16'd33);
      repeat (WN + 1) @(negedge clk);
      drain();
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
